controller_sequencer: RTL and testbench
=======================================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have parameter OPC_LDA, default 4'b0000, load-accumulator opcode.
REQ-002 SHALL have parameter OPC_ADD, default 4'b0001, add opcode.
REQ-003 SHALL have parameter OPC_SUB, default 4'b0010, subtract opcode.
REQ-004 SHALL have parameter OPC_OUT, default 4'b1110, output opcode.
REQ-005 SHALL have parameter OPC_HLT, default 4'b1111, halt opcode.
REQ-006 SHALL have port clk  input  1  single system clock, all state changes on rising edge.
REQ-007 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port ir_opcode  input  4  opcode nibble from instruction register.
REQ-009 SHALL have port pc_inc  output  1  program counter increment (active-high).
REQ-010 SHALL have port pc_en  output  1  program counter drives bus (active-high).
REQ-011 SHALL have ports n_mar_load, n_ram_en, n_ir_load, n_ir_en, n_a_load, n_b_load, n_out_load  output  1 each  active-low load/enable strobes.
REQ-012 SHALL have ports a_en, alu_sub, alu_en  output  1 each  accumulator bus enable, ALU subtract select, ALU bus enable (active-high).
REQ-013 SHALL have port t_state  output  6  one-hot ring state, bit0=T1 .. bit5=T6, 6'b0 when halted.
REQ-014 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-015 SHALL hold a registered state in {T1..T6, HALT}; all control outputs are combinational decode of state and ir_opcode.
REQ-016 SHALL advance T1->T2->T3->T4->T5->T6->T1, one state per clk edge, no early termination.
REQ-017 SHALL in T1 assert pc_en=1, n_mar_load=0 (address fetch).
REQ-018 SHALL in T2 assert pc_inc=1.
REQ-019 SHALL in T3 assert n_ram_en=0, n_ir_load=0 (instruction fetch).
REQ-020 SHALL sample ir_opcode only in T4..T6; ir_opcode is don't-care in T1..T3.
REQ-021 SHALL for LDA/ADD/SUB in T4 assert n_ir_en=0, n_mar_load=0.
REQ-022 SHALL in T5 assert n_ram_en=0 plus n_a_load=0 for LDA, n_b_load=0 for ADD/SUB.
REQ-023 SHALL in T6 assert n_a_load=0, alu_en=1 for ADD; same plus alu_sub=1 for SUB; nothing for LDA.
REQ-024 SHALL for OUT in T4 assert a_en=1, n_out_load=0; nothing in T5, T6.
REQ-025 SHALL for HLT in T4 assert no control signals and transition to HALT on the next edge.
REQ-026 SHALL treat any opcode not matching a parameter as NOP: no control asserted in T4..T6, ring continues.
REQ-027 SHALL in HALT hold all controls inactive, halted=1, t_state=6'b0, and remain until clr.
REQ-028 SHALL never assert more than one bus driver (pc_en, n_ram_en low, n_ir_en low, a_en, alu_en) in any cycle.
REQ-029 SHALL keep alu_sub=0 whenever alu_en=0.
REQ-030 SHALL while clr=1 force all control outputs inactive combinationally (active-high outputs 0, active-low 1, halted=0).

Reset
REQ-031 SHALL on a rising edge with clr=1 enter T1 from any state, including HALT and mid-instruction.
REQ-032 SHALL after reset present t_state=6'b000001, halted=0, and T1 decode once clr is low.
REQ-033 SHALL give clr priority over HLT transition when both occur at the same edge.

Verification
REQ-034 SHALL verify: clr 1 cycle, then 6 cycles ir_opcode=LDA -> t_state 01,02,04,08,10,20; T1 pc_en=1/n_mar_load=0, T2 pc_inc=1, T3 n_ir_load=0, T4 n_ir_en=0, T5 n_a_load=0, T6 no strobes.
REQ-035 SHALL verify: ir_opcode=SUB -> T5 n_b_load=0; T6 n_a_load=0, alu_en=1, alu_sub=1; ADD same with alu_sub=0.
REQ-036 SHALL verify: ir_opcode=OUT -> T4 a_en=1, n_out_load=0; T5, T6 all inactive; next cycle t_state=01.
REQ-037 SHALL verify: ir_opcode=HLT -> T4 outputs inactive, next edge halted=1, t_state=00 held 20 cycles; clr pulse -> t_state=01, halted=0.
REQ-038 SHALL verify: clr asserted in T5 of ADD -> outputs inactive that cycle, t_state=01 next edge, no n_a_load pulse.
REQ-039 SHALL verify: ir_opcode=4'b0111 over full ring -> T4..T6 inactive; random opcode run checks REQ-028 and REQ-029 every cycle.

Source files
------------

// File: rtl/controller_sequencer.sv
// Purpose : six-step ring sequencer that decodes the opcode into the control strobes of an accumulator CPU.
// Latency : outputs are a combinational decode of the registered ring state; the state advances one step per clk edge.
// Backpressure : none; the ring always advances, and only HLT (halt until clr) or clr (restart at T1) interrupt it.
// Ports:
//   clk, clr          clock; synchronous active-high restart to T1 (clr also masks every control output)
//   ir_opcode[3:0]    opcode nibble, decoded only in T4..T6
//   pc_inc, pc_en     program counter increment / program counter drives the bus
//   n_*               active-low load/enable strobes (MAR, RAM, IR load/enable, A, B, OUT)
//   a_en, alu_sub, alu_en  accumulator drives the bus, ALU subtract select, ALU drives the bus
//   t_state[5:0]      one-hot ring position (bit0=T1 .. bit5=T6), zero while halted
//   halted            high in the HALT state
module controller_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] ir_opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       n_mar_load,
  output logic       n_ram_en,
  output logic       n_ir_load,
  output logic       n_ir_en,
  output logic       n_a_load,
  output logic       n_b_load,
  output logic       n_out_load,
  output logic       a_en,
  output logic       alu_sub,
  output logic       alu_en,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;
  logic is_mem;

  // Decode chain is prioritised so that accidentally overlapping parameters
  // still select exactly one instruction class.
  assign is_lda = (ir_opcode == OPC_LDA);
  assign is_add = !is_lda && (ir_opcode == OPC_ADD);
  assign is_sub = !is_lda && !is_add && (ir_opcode == OPC_SUB);
  assign is_mem = is_lda || is_add || is_sub;
  assign is_out = !is_mem && (ir_opcode == OPC_OUT);
  assign is_hlt = !is_mem && !is_out && (ir_opcode == OPC_HLT);

  // clr wins over every other transition, including the T4->HALT step.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_T1;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = S_T1;
    pc_inc     = 1'b0;
    pc_en      = 1'b0;
    n_mar_load = 1'b1;
    n_ram_en   = 1'b1;
    n_ir_load  = 1'b1;
    n_ir_en    = 1'b1;
    n_a_load   = 1'b1;
    n_b_load   = 1'b1;
    n_out_load = 1'b1;
    a_en       = 1'b0;
    alu_sub    = 1'b0;
    alu_en     = 1'b0;
    t_state    = 6'b000000;
    halted     = 1'b0;

    case (state)
      S_T1: begin
        t_state    = 6'b000001;
        state_nxt  = S_T2;
        pc_en      = 1'b1;
        n_mar_load = 1'b0;
      end
      S_T2: begin
        t_state   = 6'b000010;
        state_nxt = S_T3;
        pc_inc    = 1'b1;
      end
      S_T3: begin
        t_state   = 6'b000100;
        state_nxt = S_T4;
        n_ram_en  = 1'b0;
        n_ir_load = 1'b0;
      end
      S_T4: begin
        t_state   = 6'b001000;
        state_nxt = S_T5;
        if (is_mem) begin
          // Operand address comes from the IR's low nibble.
          n_ir_en    = 1'b0;
          n_mar_load = 1'b0;
        end else if (is_out) begin
          a_en       = 1'b1;
          n_out_load = 1'b0;
        end else if (is_hlt) begin
          state_nxt = S_HALT;
        end
      end
      S_T5: begin
        t_state   = 6'b010000;
        state_nxt = S_T6;
        if (is_mem) begin
          n_ram_en = 1'b0;
          if (is_lda) begin
            n_a_load = 1'b0;
          end else begin
            n_b_load = 1'b0;
          end
        end
      end
      S_T6: begin
        t_state   = 6'b100000;
        state_nxt = S_T1;
        if (is_add || is_sub) begin
          n_a_load = 1'b0;
          alu_en   = 1'b1;
          alu_sub  = is_sub;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
        halted    = 1'b1;
      end
      default: begin
        state_nxt = S_T1;
      end
    endcase

    // clr masks the decode in the same cycle so no strobe can fire while
    // the sequencer is being restarted.
    if (clr) begin
      pc_inc     = 1'b0;
      pc_en      = 1'b0;
      n_mar_load = 1'b1;
      n_ram_en   = 1'b1;
      n_ir_load  = 1'b1;
      n_ir_en    = 1'b1;
      n_a_load   = 1'b1;
      n_b_load   = 1'b1;
      n_out_load = 1'b1;
      a_en       = 1'b0;
      alu_sub    = 1'b0;
      alu_en     = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  // Bit positions of the "asserted" control vector (1 = strobe active,
  // independent of pin polarity).
  localparam int B_PC_INC   = 0;
  localparam int B_PC_EN    = 1;
  localparam int B_MAR_LOAD = 2;
  localparam int B_RAM_EN   = 3;
  localparam int B_IR_LOAD  = 4;
  localparam int B_IR_EN    = 5;
  localparam int B_A_LOAD   = 6;
  localparam int B_B_LOAD   = 7;
  localparam int B_OUT_LOAD = 8;
  localparam int B_A_EN     = 9;
  localparam int B_ALU_SUB  = 10;
  localparam int B_ALU_EN   = 11;
  localparam int B_HALTED   = 12;

  logic       clk;
  logic       clr;
  logic [3:0] ir_opcode;
  logic       pc_inc, pc_en, n_mar_load, n_ram_en, n_ir_load, n_ir_en;
  logic       n_a_load, n_b_load, n_out_load, a_en, alu_sub, alu_en;
  logic [5:0] t_state;
  logic       halted;

  int checks = 0;
  int errors = 0;
  // Reference position in the instruction: 1..6 = step, 0 = halted, -1 = unknown (before first clr).
  int ph = -1;

  controller_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .ir_opcode  (ir_opcode),
    .pc_inc     (pc_inc),
    .pc_en      (pc_en),
    .n_mar_load (n_mar_load),
    .n_ram_en   (n_ram_en),
    .n_ir_load  (n_ir_load),
    .n_ir_en    (n_ir_en),
    .n_a_load   (n_a_load),
    .n_b_load   (n_b_load),
    .n_out_load (n_out_load),
    .a_en       (a_en),
    .alu_sub    (alu_sub),
    .alu_en     (alu_en),
    .t_state    (t_state),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which strobes an instruction step should raise, written as the
  // micro-operation table of the machine.
  function automatic logic [12:0] expect_ctrl(input int p, input logic [3:0] op, input logic c);
    logic [12:0] e;
    e = '0;
    if (c) return e;
    case (p)
      0: e[B_HALTED] = 1'b1;
      1: begin e[B_PC_EN] = 1'b1; e[B_MAR_LOAD] = 1'b1; end
      2: e[B_PC_INC] = 1'b1;
      3: begin e[B_RAM_EN] = 1'b1; e[B_IR_LOAD] = 1'b1; end
      4: begin
        if (op == LDA || op == ADD || op == SUB) begin
          e[B_IR_EN] = 1'b1; e[B_MAR_LOAD] = 1'b1;
        end else if (op == OUT) begin
          e[B_A_EN] = 1'b1; e[B_OUT_LOAD] = 1'b1;
        end
      end
      5: begin
        if (op == LDA) begin
          e[B_RAM_EN] = 1'b1; e[B_A_LOAD] = 1'b1;
        end else if (op == ADD || op == SUB) begin
          e[B_RAM_EN] = 1'b1; e[B_B_LOAD] = 1'b1;
        end
      end
      6: begin
        if (op == ADD || op == SUB) begin
          e[B_A_LOAD] = 1'b1; e[B_ALU_EN] = 1'b1; e[B_ALU_SUB] = (op == SUB);
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check near the
  // falling edge, then let the reference follow the rising edge.
  task automatic cycle(input logic [3:0] op, input logic c);
    logic [12:0] obs;
    int drivers;
    ir_opcode = op;
    clr       = c;
    #4;
    obs = {halted, alu_en, alu_sub, a_en, ~n_out_load, ~n_b_load, ~n_a_load,
           ~n_ir_en, ~n_ir_load, ~n_ram_en, ~n_mar_load, pc_en, pc_inc};
    check("controls", 32'(obs), 32'(expect_ctrl(ph, op, c)));
    if (ph >= 0) begin
      check("t_state", 32'(t_state), (ph == 0) ? 32'd0 : (32'd1 << (ph - 1)));
    end
    drivers = int'(pc_en) + int'(!n_ram_en) + int'(!n_ir_en) + int'(a_en) + int'(alu_en);
    check("one_bus_driver", 32'(drivers <= 1), 32'd1);
    check("alu_sub_gated", 32'(alu_sub && !alu_en), 32'd0);
    @(posedge clk);
    if (c)                     ph = 1;
    else if (ph == 0)          ph = 0;
    else if (ph == 4 && op == HLT) ph = 0;
    else if (ph > 0)           ph = (ph % 6) + 1;
    #1;
  endtask

  // Full instruction: fetch steps see a random (don't-care) opcode.
  task automatic run_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) begin
      cycle((i < 3) ? 4'($urandom) : op, 1'b0);
    end
  endtask

  initial begin
    clr       = 1'b1;
    ir_opcode = LDA;

    // Reset from an unknown state.
    cycle(LDA, 1'b1);
    check("reset_t_state", 32'(t_state), 32'h01);
    check("reset_halted", 32'(halted), 32'd0);

    // Directed instruction rings.
    run_instr(LDA);
    run_instr(SUB);
    run_instr(ADD);
    run_instr(OUT);
    run_instr(4'b0111);
    check("ring_wraps_t1", 32'(t_state), 32'h01);

    // Halt, stay halted, then restart with clr.
    run_instr(HLT);
    for (int i = 0; i < 20; i++) cycle(4'($urandom), 1'b0);
    check("halt_held", 32'(halted), 32'd1);
    cycle(HLT, 1'b1);
    check("halt_clr_t_state", 32'(t_state), 32'h01);
    check("halt_clr_halted", 32'(halted), 32'd0);

    // clr in T5 of ADD aborts the instruction.
    for (int i = 0; i < 4; i++) cycle(ADD, 1'b0);
    cycle(ADD, 1'b1);
    check("abort_t_state", 32'(t_state), 32'h01);

    // clr coincides with the T4->HALT edge: clr wins.
    for (int i = 0; i < 3; i++) cycle(HLT, 1'b0);
    cycle(HLT, 1'b1);
    check("clr_beats_hlt", 32'(t_state), 32'h01);

    // Random opcodes with occasional clr.
    for (int i = 0; i < 600; i++) begin
      cycle(4'($urandom), ($urandom_range(24, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
